// File: rtl/pcs_rx_block_decoder.sv
// pcs_rx_block_decoder: 66b descrambled blocks -> CGMII words (64b data + 8b ctrl).
// Classifies each block as C/S/D/T/E and runs the receive FSM with one-block lookahead.
// Each held block is decoded when its successor arrives, because a T block is only
// legal if the following block is S or C.
// Optional feature: define PCS_RX_DEC_ERR_COUNT_EN to build the saturating error counter.
module pcs_rx_block_decoder #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int LEN_DATA        = 64,
  parameter int LEN_CTRL        = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic [LEN_CODED_BLOCK-1:0] i_data,
  input  logic                       i_tag,
  input  logic                       i_rx_fault,
  output logic [LEN_DATA-1:0]        o_data,
  output logic [LEN_CTRL-1:0]        o_ctrl,
  output logic                       o_valid,
  output logic                       o_tag,
  output logic [15:0]                o_err_count
);

  localparam logic [LEN_DATA-1:0] LBLOCK_D = 64'h9C00000107070707;
  localparam logic [LEN_CTRL-1:0] LBLOCK_C = 8'h8F;
  localparam logic [LEN_DATA-1:0] EBLOCK_D = {8{8'hFE}};
  localparam logic [LEN_CTRL-1:0] EBLOCK_C = 8'hFF;

  typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} state_t;
  typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_t;

  // Number of data octets carried by a terminate block, from its type field.
  function automatic logic [2:0] t_len(input logic [7:0] typ);
    logic [2:0] k;
    case (typ)
      8'h87:   k = 3'd0;
      8'h99:   k = 3'd1;
      8'hAA:   k = 3'd2;
      8'hB4:   k = 3'd3;
      8'hCC:   k = 3'd4;
      8'hD2:   k = 3'd5;
      8'hE1:   k = 3'd6;
      default: k = 3'd7;
    endcase
    return k;
  endfunction

  // Block class from sync header, type field and control-code content.
  function automatic blk_t classify(input logic [LEN_CODED_BLOCK-1:0] b);
    blk_t r;
    r = BLK_E;
    if (b[65:64] == 2'b01) begin
      r = BLK_D;
    end else if (b[65:64] == 2'b10) begin
      case (b[63:56])
        8'h1E: begin
          r = BLK_C;
          // Only idle and error control codes are accepted in an all-control block.
          for (int i = 0; i < 8; i++)
            if (b[55-7*i -: 7] != 7'h00 && b[55-7*i -: 7] != 7'h1E) r = BLK_E;
        end
        8'h4B:   if (b[31:0] == 32'd0) r = BLK_C;
        8'h78:   r = BLK_S;
        8'h87, 8'h99, 8'hAA, 8'hB4,
        8'hCC, 8'hD2, 8'hE1, 8'hFF: r = BLK_T;
        default: r = BLK_E;
      endcase
    end
    return r;
  endfunction

  // CGMII word {data, ctrl} for a block already known to be C/S/D/T.
  function automatic logic [LEN_DATA+LEN_CTRL-1:0] decode(input logic [LEN_CODED_BLOCK-1:0] b);
    logic [LEN_DATA-1:0] d;
    logic [LEN_CTRL-1:0] c;
    logic [2:0]          k;
    int                  kk;
    d  = EBLOCK_D;
    c  = EBLOCK_C;
    k  = t_len(b[63:56]);
    kk = int'(k);
    if (b[65:64] == 2'b01) begin
      d = b[63:0];
      c = 8'h00;
    end else begin
      case (b[63:56])
        8'h1E: begin
          for (int i = 0; i < 8; i++)
            d[63-8*i -: 8] = (b[55-7*i -: 7] == 7'h1E) ? 8'hFE : 8'h07;
          c = 8'hFF;
        end
        8'h4B: begin
          d = {8'h9C, b[55:32], 32'h07070707};
          c = 8'h8F;
        end
        8'h78: begin
          d = {8'hFB, b[55:0]};
          c = 8'h80;
        end
        default: begin
          for (int i = 0; i < 8; i++) begin
            if (i < kk)       d[63-8*i -: 8] = b[55-8*i -: 8];
            else if (i == kk) d[63-8*i -: 8] = 8'hFD;
            else              d[63-8*i -: 8] = 8'h07;
          end
          c = 8'hFF >> k;
        end
      endcase
    end
    return {d, c};
  endfunction

  state_t                     state_q, state_d, fsm_nxt;
  logic [LEN_CODED_BLOCK-1:0] hold_q, hold_d;
  logic                       htag_q, htag_d;
  logic                       have_q, have_d;
  logic [LEN_DATA-1:0]        data_q, data_d;
  logic [LEN_CTRL-1:0]        ctrl_q, ctrl_d;
  logic                       valid_q, valid_d;
  logic                       tag_q, tag_d;
  blk_t                       cls_k, cls_n;
  logic                       next_ok;

  assign cls_k   = classify(hold_q);
  assign cls_n   = classify(i_data);
  assign next_ok = (cls_n == BLK_S) || (cls_n == BLK_C);

  // FSM state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)       state_q <= RX_INIT;
    else if (i_enable) state_q <= state_d;
  end

  // Destination state for the held block given the incoming block as lookahead.
  always_comb begin
    fsm_nxt = RX_E;
    case (state_q)
      RX_INIT, RX_C, RX_T: begin
        if (cls_k == BLK_C)      fsm_nxt = RX_C;
        else if (cls_k == BLK_S) fsm_nxt = RX_D;
      end
      RX_D: begin
        if (cls_k == BLK_D)                 fsm_nxt = RX_D;
        else if (cls_k == BLK_T && next_ok) fsm_nxt = RX_T;
      end
      RX_E: begin
        if (cls_k == BLK_C)                 fsm_nxt = RX_C;
        else if (cls_k == BLK_D)            fsm_nxt = RX_D;
        else if (cls_k == BLK_T && next_ok) fsm_nxt = RX_T;
      end
      default: fsm_nxt = RX_E;
    endcase
  end

  // Lookahead buffer, state update and output word selection for one enabled cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    htag_d  = htag_q;
    have_d  = have_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    tag_d   = tag_q;
    valid_d = 1'b0;
    if (i_rx_fault) begin
      state_d = RX_INIT;
      have_d  = 1'b0;
      data_d  = LBLOCK_D;
      ctrl_d  = LBLOCK_C;
      valid_d = i_valid;
    end else if (i_valid) begin
      hold_d = i_data;
      htag_d = i_tag;
      have_d = 1'b1;
      if (have_q) begin
        state_d = fsm_nxt;
        if (fsm_nxt == RX_E) {data_d, ctrl_d} = {EBLOCK_D, EBLOCK_C};
        else                 {data_d, ctrl_d} = decode(hold_q);
        tag_d   = htag_q;
        valid_d = 1'b1;
      end
    end
  end

  // Datapath registers; everything holds while the clock enable is low.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      hold_q  <= '0;
      htag_q  <= 1'b0;
      have_q  <= 1'b0;
      data_q  <= LBLOCK_D;
      ctrl_q  <= LBLOCK_C;
      valid_q <= 1'b0;
      tag_q   <= 1'b0;
    end else if (i_enable) begin
      hold_q  <= hold_d;
      htag_q  <= htag_d;
      have_q  <= have_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign o_data  = data_q;
  assign o_ctrl  = ctrl_q;
  assign o_valid = valid_q;
  assign o_tag   = tag_q;

`ifdef PCS_RX_DEC_ERR_COUNT_EN
  logic [15:0] err_q, err_d;
  logic        err_hit;

  // A word counts as an error when it is emitted and equals the error block.
  assign err_hit = valid_d && (data_d == EBLOCK_D) && (ctrl_d == EBLOCK_C);
  assign err_d   = (err_hit && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;

  // Saturating error counter.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)       err_q <= 16'h0000;
    else if (i_enable) err_q <= err_d;
  end

  assign o_err_count = err_q;
`else
  assign o_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pcs_rx_block_decoder.sv
// Scoreboard bench for pcs_rx_block_decoder: a block-level reference model pushes
// expected CGMII words when stimulus is issued; a monitor pops on every o_valid.
module tb_pcs_rx_block_decoder;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_valid, i_tag, i_rx_fault;
  logic [65:0] i_data;
  logic [63:0] o_data;
  logic [7:0]  o_ctrl;
  logic        o_valid, o_tag;
  logic [15:0] o_err_count;

  always #5 clk = ~clk;

  pcs_rx_block_decoder dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_data(i_data), .i_tag(i_tag), .i_rx_fault(i_rx_fault),
    .o_data(o_data), .o_ctrl(o_ctrl), .o_valid(o_valid), .o_tag(o_tag),
    .o_err_count(o_err_count)
  );

  localparam logic [63:0] LB = 64'h9C00000107070707;
  localparam logic [63:0] EB = 64'hFEFEFEFEFEFEFEFE;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic        t;
    bit          ct;
    int          ec;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_pass = 0;
  logic [7:0]  ttype [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  // reference model state
  byte         m_st;
  logic [65:0] m_hold;
  logic        m_tag;
  bit          m_have;
  int          m_ec;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic int tlen(input logic [7:0] typ);
    for (int i = 0; i < 8; i++) if (ttype[i] == typ) return i;
    return -1;
  endfunction

  function automatic byte cls(input logic [65:0] b);
    if (b[65:64] == 2'b01) return "D";
    if (b[65:64] != 2'b10) return "E";
    if (b[63:56] == 8'h1E) begin
      for (int i = 0; i < 8; i++)
        if (!(b[55-7*i -: 7] == 7'h00 || b[55-7*i -: 7] == 7'h1E)) return "E";
      return "C";
    end
    if (b[63:56] == 8'h4B) return (b[31:0] == 32'd0) ? "C" : "E";
    if (b[63:56] == 8'h78) return "S";
    if (tlen(b[63:56]) >= 0) return "T";
    return "E";
  endfunction

  function automatic byte trans(input byte st, input byte ck, input byte cn);
    bit nok;
    nok = (cn == "S") || (cn == "C");
    case (st)
      "I", "C", "T": return (ck == "C") ? "C" : (ck == "S") ? "D" : "E";
      "D": begin
        if (ck == "D") return "D";
        if (ck == "T" && nok) return "T";
        return "E";
      end
      default: begin
        if (ck == "C") return "C";
        if (ck == "D") return "D";
        if (ck == "T" && nok) return "T";
        return "E";
      end
    endcase
  endfunction

  // Lane-by-lane CGMII reconstruction of a valid block.
  task automatic mdec(input logic [65:0] b, output logic [63:0] d, output logic [7:0] c);
    logic [7:0] lane [8];
    bit         cb [8];
    byte        k;
    int         n;
    k = cls(b);
    for (int i = 0; i < 8; i++) begin lane[i] = 8'h07; cb[i] = 1'b1; end
    if (k == "D") begin
      for (int i = 0; i < 8; i++) begin lane[i] = b[63-8*i -: 8]; cb[i] = 1'b0; end
    end else if (k == "S") begin
      lane[0] = 8'hFB;
      for (int i = 1; i < 8; i++) begin lane[i] = b[63-8*i -: 8]; cb[i] = 1'b0; end
    end else if (k == "C" && b[63:56] == 8'h1E) begin
      for (int i = 0; i < 8; i++) lane[i] = (b[55-7*i -: 7] == 7'h00) ? 8'h07 : 8'hFE;
    end else if (k == "C") begin
      lane[0] = 8'h9C;
      for (int i = 1; i < 4; i++) begin lane[i] = b[63-8*i -: 8]; cb[i] = 1'b0; end
    end else begin
      n = tlen(b[63:56]);
      for (int i = 0; i < n; i++) begin lane[i] = b[55-8*i -: 8]; cb[i] = 1'b0; end
      lane[n] = 8'hFD;
    end
    for (int i = 0; i < 8; i++) begin d[63-8*i -: 8] = lane[i]; c[7-i] = cb[i]; end
  endtask

  task automatic model_reset();
    m_st = "I"; m_have = 0; m_hold = '0; m_tag = 0; m_ec = 0;
  endtask

  task automatic model_step(input logic v, input logic [65:0] d, input logic t,
                            input logic en, input logic f);
    exp_t e;
    byte  ns;
    if (!en) return;
    if (f) begin
      m_have = 0; m_st = "I";
      if (v) begin e.d = LB; e.c = 8'h8F; e.t = 1'b0; e.ct = 0; e.ec = m_ec; q.push_back(e); end
      return;
    end
    if (!v) return;
    if (m_have) begin
      ns = trans(m_st, cls(m_hold), cls(d));
      if (ns == "E") begin e.d = EB; e.c = 8'hFF; end
      else mdec(m_hold, e.d, e.c);
`ifdef PCS_RX_DEC_ERR_COUNT_EN
      if (e.d == EB && e.c == 8'hFF && m_ec < 65535) m_ec++;
`endif
      e.t = m_tag; e.ct = 1; e.ec = m_ec;
      q.push_back(e);
      m_st = ns;
    end
    m_hold = d; m_tag = t; m_have = 1;
  endtask

  task automatic drive(input logic v, input logic [65:0] d, input logic t,
                       input logic en, input logic f);
    @(negedge clk);
    i_valid = v; i_data = d; i_tag = t; i_enable = en; i_rx_fault = f;
    model_step(v, d, t, en, f);
  endtask

  task automatic send(input logic [65:0] d);
    drive(1'b1, d, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
  endtask

  // kind: 0 idle, 1 ordered set, 2 start, 3 data, 4 terminate, 5 junk; sub picks a variant
  function automatic logic [65:0] mk(input int kind, input int sub);
    logic [95:0] r;
    logic [65:0] b;
    int          s;
    r = {$urandom, $urandom, $urandom};
    b = r[65:0];
    case (kind)
      0: begin
        b = {2'b10, 8'h1E, 56'h0};
        for (int i = 0; i < 8; i++) b[55-7*i -: 7] = ($urandom_range(0, 7) == 0) ? 7'h1E : 7'h00;
      end
      1: b = {2'b10, 8'h4B, r[23:0], 32'h0};
      2: b = {2'b10, 8'h78, r[55:0]};
      3: b = {2'b01, r[63:0]};
      4: begin
        s = (sub < 0) ? int'($urandom_range(0, 7)) : sub;
        b = {2'b10, ttype[s], r[55:0]};
      end
      default: begin
        s = (sub < 0) ? int'($urandom_range(0, 3)) : sub;
        case (s)
          0: b = {($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, r[63:0]};
          1: b = {2'b10, 8'h2D, r[55:0]};
          2: b = {2'b10, 8'h4B, r[23:0], 4'hF, 28'h0};
          default: b = {2'b10, 8'h1E, 7'h2A, 49'h0};
        endcase
      end
    endcase
    return b;
  endfunction

  task automatic check_reset_state(input string nm);
    chk({nm, "_data"},  o_data, LB);
    chk({nm, "_ctrl"},  64'(o_ctrl), 64'h8F);
    chk({nm, "_valid"}, 64'(o_valid), 64'h0);
    chk({nm, "_tag"},   64'(o_tag), 64'h0);
    chk({nm, "_errc"},  64'(o_err_count), 64'h0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    i_valid = 0; i_enable = 1; i_rx_fault = 0;
    #2 i_reset = 1;
    #1 check_reset_state("mid_reset");
    q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    i_reset = 0;
  endtask

  // monitor: only edges where the DUT was enabled can present a new word
  always @(posedge clk) begin
    bit   en_s;
    exp_t e;
    en_s = i_enable && !i_reset;
    #1;
    if (en_s && o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_word", o_data, 64'hx);
      end else begin
        e = q.pop_front();
        chk("word_data", o_data, e.d);
        chk("word_ctrl", 64'(o_ctrl), 64'(e.c));
        if (e.ct) chk("word_tag", 64'(o_tag), 64'(e.t));
        chk("err_count", 64'(o_err_count), 64'(e.ec));
      end
    end
  end

  initial begin
    bit inframe;
    int k;
    i_reset = 1; i_enable = 0; i_valid = 0; i_tag = 0; i_rx_fault = 0; i_data = '0;
    model_reset();
    #3 check_reset_state("reset");
    @(negedge clk); @(negedge clk);
    i_reset = 0;

    // T1: frame S D D T3 then idles
    send(mk(2, 0)); send(mk(3, 0)); send(mk(3, 0)); send(mk(4, 3));
    send({2'b10, 8'h1E, 56'h0}); send({2'b10, 8'h1E, 56'h0});
    // T2: data while in RX_C, then recovery on idle
    send(mk(3, 0)); send({2'b10, 8'h1E, 56'h0}); send({2'b10, 8'h1E, 56'h0});
    // T3: T7 followed by D, then D continues from RX_E
    send(mk(2, 0)); send(mk(3, 0)); send(mk(4, 7)); send(mk(3, 0)); send(mk(4, 0));
    send(mk(0, 0)); send(mk(0, 0));
    // T4: bad sync, undefined type, ordered set with bad O-code
    send(mk(5, 0)); send(mk(5, 1)); send(mk(5, 2)); send(mk(0, 0)); send(mk(1, 0));
    send(mk(0, 0));
    // T5: fault pulse mid-frame, then C C
    send(mk(2, 0)); send(mk(3, 0));
    drive(1'b1, mk(3, 0), 1'b0, 1'b1, 1'b1);
    send({2'b10, 8'h1E, 56'h0}); send({2'b10, 8'h1E, 56'h0}); send(mk(0, 0));

    // T6: random traffic with valid gaps, enable stalls, rare faults and a mid-frame reset
    inframe = 0;
    for (int n = 0; n < 700; n++) begin
      while ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) != 0) drive(1'b0, mk(3, 0), 1'b0, 1'b1, 1'b0);
        else drive(1'($urandom_range(0, 1)), mk(3, 0), 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      end
      if (n == 350) mid_reset();
      if ($urandom_range(0, 99) < 2) begin
        drive(1'($urandom_range(0, 1)), mk(3, 0), 1'b0, 1'b1, 1'b1);
        inframe = 0;
      end
      k = $urandom_range(0, 99);
      if (k < 4) begin send(mk(5, -1)); end
      else if (inframe) begin
        if (k < 75) send(mk(3, 0));
        else begin send(mk(4, -1)); inframe = 0; end
      end else begin
        if (k < 60) send(mk(0, 0));
        else if (k < 70) send(mk(1, 0));
        else begin send(mk(2, 0)); inframe = 1; end
      end
    end
    repeat (4) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("drain", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
